// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID control decoder and its pipeline: opcode/funct/rt values,
// control-slice field codes, HI/LO latency defaults and the packed control word.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J   = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_ADDIU = 6'h09, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LW     = 6'h23, OP_LBU = 6'h24, OP_SW  = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_JR   = 6'h08, F_MFHI  = 6'h10, F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12, F_MTLO = 6'h13, F_MULT  = 6'h18, F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV  = 6'h1A, F_DIVU = 6'h1B, F_ADDU  = 6'h21, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_SLT   = 6'h2A;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

    // EX slice = {ALUOp, S0_S2}; S0_S2 selects operand B (LINK = JalAdder output, PC+8)
    localparam logic [2:0] ALU_NOP = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4, ALU_SLT = 3'd5, ALU_SLL = 3'd6, ALU_PASS = 3'd7;
    localparam logic [1:0] SRC_REG = 2'b00, SRC_SIMM = 2'b01, SRC_UIMM = 2'b10, SRC_LINK = 2'b11;

    // MEM slice = {RW, Enable, Size[1:0], SE, MEM_MUX}; Size 01 byte, 11 word
    localparam logic [5:0] MEM_LB  = 6'b0_1_01_1_1, MEM_LBU = 6'b0_1_01_0_1;
    localparam logic [5:0] MEM_LW  = 6'b0_1_11_0_1, MEM_SW  = 6'b1_1_11_0_0;

    // WB slice = {Load, MemtoReg, LoEnable, RegFileEnable, HiEnable}
    localparam logic [4:0] WB_RF = 5'b00010, WB_HI = 5'b00001, WB_LO = 5'b00100, WB_LOAD = 5'b11010;

    localparam logic [1:0] IF_COND = 2'b10, IF_JUMP = 2'b01;
    localparam logic [1:0] WD_RT = 2'b01, WD_R31 = 2'b10, WD_RD = 2'b11;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

    typedef struct packed {
        logic [4:0] ex;
        logic [5:0] mem;
        logic [4:0] wb;
    } ctrl_word_t;

    localparam int CTRL_W = $bits(ctrl_word_t);

    typedef enum logic {ST_RUN, ST_MD_BUSY} md_state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decoder: instr -> IF/ID control plus the EX/MEM/WB control word,
// with HI/LO classification and an unknown-encoding flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]       i_instr,
    output logic [1:0]        o_if_ctrl,
    output logic [1:0]        o_wdest,
    output logic [CTRL_W-1:0] o_word,
    output logic              o_is_mul,
    output logic              o_is_div,
    output logic              o_is_hilo,
    output logic              o_illegal
);
    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rt;
    ctrl_word_t w_word;

    assign w_op   = i_instr[31:26];
    assign w_rt   = i_instr[20:16];
    assign w_fn   = i_instr[5:0];
    assign o_word = w_word;

    always_comb begin
        w_word    = '0;
        o_if_ctrl = '0;
        o_wdest   = '0;
        o_is_mul  = 1'b0;
        o_is_div  = 1'b0;
        o_is_hilo = 1'b0;
        o_illegal = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                o_wdest   = WD_RD;
                w_word.wb = WB_RF;
                case (w_fn)
                    F_SLL:  w_word.ex = {ALU_SLL, SRC_REG};
                    F_ADDU: w_word.ex = {ALU_ADD, SRC_REG};
                    F_SUBU: w_word.ex = {ALU_SUB, SRC_REG};
                    F_AND:  w_word.ex = {ALU_AND, SRC_REG};
                    F_OR:   w_word.ex = {ALU_OR,  SRC_REG};
                    F_SLT:  w_word.ex = {ALU_SLT, SRC_REG};
                    F_MFHI, F_MFLO: begin
                        w_word.ex = {ALU_PASS, SRC_REG};
                        o_is_hilo = 1'b1;
                    end
                    F_JR: begin
                        o_if_ctrl = IF_JUMP;
                        o_wdest   = '0;
                        w_word.wb = '0;
                    end
                    F_MTHI, F_MTLO: begin
                        o_wdest   = '0;
                        w_word.wb = (w_fn == F_MTHI) ? WB_HI : WB_LO;
                        o_is_hilo = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        o_wdest   = '0;
                        w_word.wb = WB_HI | WB_LO;
                        o_is_hilo = 1'b1;
                        o_is_mul  = (w_fn == F_MULT) || (w_fn == F_MULTU);
                        o_is_div  = (w_fn == F_DIV)  || (w_fn == F_DIVU);
                    end
                    default: begin
                        o_wdest   = '0;
                        w_word.wb = '0;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OP_REGIMM: begin
                case (w_rt)
                    RT_BLTZ, RT_BGEZ: o_if_ctrl = IF_COND;
                    RT_BLTZAL, RT_BGEZAL: begin
                        o_if_ctrl = IF_COND;
                        o_wdest   = WD_R31;
                        w_word.ex = {ALU_PASS, SRC_LINK};
                        w_word.wb = WB_RF;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_J:   o_if_ctrl = IF_JUMP;
            OP_JAL: begin
                o_if_ctrl = IF_JUMP;
                o_wdest   = WD_R31;
                w_word.ex = {ALU_PASS, SRC_LINK};
                w_word.wb = WB_RF;
            end
            OP_BEQ, OP_BNE: o_if_ctrl = IF_COND;
            OP_ADDIU, OP_LUI: begin
                o_wdest   = WD_RT;
                w_word.ex = (w_op == OP_LUI) ? {ALU_PASS, SRC_UIMM} : {ALU_ADD, SRC_SIMM};
                w_word.wb = WB_RF;
            end
            OP_LB, OP_LBU, OP_LW: begin
                o_wdest    = WD_RT;
                w_word.ex  = {ALU_ADD, SRC_SIMM};
                w_word.mem = (w_op == OP_LW) ? MEM_LW : ((w_op == OP_LB) ? MEM_LB : MEM_LBU);
                w_word.wb  = WB_LOAD;
            end
            OP_SW: begin
                w_word.ex  = {ALU_ADD, SRC_SIMM};
                w_word.mem = MEM_SW;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID-stage control: decode, issue/bubble logic, EX/MEM/WB control latches and the HI/LO busy FSM.
// Optional CTRL_ILLEGAL_TRAP_EN turns unknown encodings into a trap pulse plus an EX bubble.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int EX_W    = 5,
    parameter int MEM_W   = 6,
    parameter int WB_W    = 5,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             hz_stall,
    input  logic             flush,
    output logic             id_ready,
    output logic [1:0]       id_if_ctrl,
    output logic [1:0]       id_wdest,
    output logic [EX_W-1:0]  ex_ctrl,
    output logic             ex_valid,
    output logic [MEM_W-1:0] mem_ctrl,
    output logic             mem_valid,
    output logic [WB_W-1:0]  wb_ctrl,
    output logic             wb_valid,
    output logic             md_busy,
    output logic             illegal_instr
);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    logic [1:0]        w_if_ctrl;
    logic [1:0]        w_wdest;
    logic [CTRL_W-1:0] w_dec_word;
    ctrl_word_t        w_word;
    logic              w_is_mul, w_is_div, w_is_hilo, w_illegal;
    logic              w_md_block, w_trap, w_issue;

    md_state_e         r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

    ctrl_word_t        r_word_p0;
    logic              r_vld_p0;
    logic [5:0]        r_mem_p1;
    logic [4:0]        r_wb_p1;
    logic              r_vld_p1;
    logic [4:0]        r_wb_p2;
    logic              r_vld_p2;

    ctrl_decode u_dec (
        .i_instr   (id_instr),
        .o_if_ctrl (w_if_ctrl),
        .o_wdest   (w_wdest),
        .o_word    (w_dec_word),
        .o_is_mul  (w_is_mul),
        .o_is_div  (w_is_div),
        .o_is_hilo (w_is_hilo),
        .o_illegal (w_illegal)
    );

    assign w_word     = w_dec_word;
    assign md_busy    = (r_state == ST_MD_BUSY);
    assign w_md_block = md_busy & w_is_hilo;
    // A trapped instruction is consumed even under a stall so the pulse cannot repeat.
    assign w_trap     = TRAP_EN & rst_n & id_valid & ~flush & w_illegal;
    assign w_issue    = rst_n & id_valid & ~flush & ~hz_stall & ~w_md_block & ~w_trap;

    assign id_ready      = rst_n & (w_issue | flush | w_trap);
    assign illegal_instr = w_trap;
    assign id_if_ctrl    = id_valid ? w_if_ctrl : 2'b00;
    assign id_wdest      = id_valid ? w_wdest   : 2'b00;

    assign ex_ctrl   = EX_W'(r_word_p0.ex);
    assign ex_valid  = r_vld_p0;
    assign mem_ctrl  = MEM_W'(r_mem_p1);
    assign mem_valid = r_vld_p1;
    assign wb_ctrl   = WB_W'(r_wb_p2);
    assign wb_valid  = r_vld_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word_p0 <= '0;
            r_vld_p0  <= 1'b0;
            r_mem_p1  <= '0;
            r_wb_p1   <= '0;
            r_vld_p1  <= 1'b0;
            r_wb_p2   <= '0;
            r_vld_p2  <= 1'b0;
        end else begin
            // ID -> EX
            r_word_p0 <= w_issue ? w_word : '0;
            r_vld_p0  <= w_issue;
            // EX -> MEM
            r_mem_p1  <= r_word_p0.mem;
            r_wb_p1   <= r_word_p0.wb;
            r_vld_p1  <= r_vld_p0;
            // MEM -> WB
            r_wb_p2   <= r_wb_p1;
            r_vld_p2  <= r_vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_issue && w_is_mul) begin
                    w_cnt_nxt = MUL_LOAD;
                    if (MUL_LOAD != '0) w_state_nxt = ST_MD_BUSY;
                end else if (w_issue && w_is_div) begin
                    w_cnt_nxt = DIV_LOAD;
                    if (DIV_LOAD != '0) w_state_nxt = ST_MD_BUSY;
                end
            end
            ST_MD_BUSY: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (w_cnt_nxt == '0) w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed-vector bench for ctrl_pipe_unit: reset, load path, stall/flush bubbles, DIV occupancy,
// link decoding and unknown-opcode handling (trap variant selected by CTRL_ILLEGAL_TRAP_EN).
module tb_ctrl_pipe_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        id_valid, hz_stall, flush;
    logic        id_ready, ex_valid, mem_valid, wb_valid, md_busy, illegal_instr;
    logic [1:0]  id_if_ctrl, id_wdest;
    logic [4:0]  ex_ctrl, wb_ctrl;
    logic [5:0]  mem_ctrl;

    int n_chk = 0;
    int n_bad = 0;
    int busy_cnt;
    int early_ready;

    // Instruction words: rs=1, rt=2, rd=3 / imm=4
    localparam logic [31:0] I_ADDIU  = {6'h09, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] I_LBU    = {6'h24, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] I_LW     = {6'h23, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] I_JAL    = {6'h03, 26'h0000010};
    localparam logic [31:0] I_BGEZAL = {6'h01, 5'd1, 5'h11, 16'h0004};
    localparam logic [31:0] I_BEQ    = {6'h04, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] I_SUBU   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h23};
    localparam logic [31:0] I_ADDU   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    localparam logic [31:0] I_DIV    = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h1A};
    localparam logic [31:0] I_MFLO   = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h12};
    localparam logic [31:0] I_BAD    = {6'h3F, 26'h0};

    ctrl_pipe_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_instr      (id_instr),
        .id_valid      (id_valid),
        .hz_stall      (hz_stall),
        .flush         (flush),
        .id_ready      (id_ready),
        .id_if_ctrl    (id_if_ctrl),
        .id_wdest      (id_wdest),
        .ex_ctrl       (ex_ctrl),
        .ex_valid      (ex_valid),
        .mem_ctrl      (mem_ctrl),
        .mem_valid     (mem_valid),
        .wb_ctrl       (wb_ctrl),
        .wb_valid      (wb_valid),
        .md_busy       (md_busy),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
        @(negedge clk);
        id_instr = ins;
        id_valid = v;
        hz_stall = st;
        flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; id_instr = '0; id_valid = 1'b0; hz_stall = 1'b0; flush = 1'b0;

        // reset held two cycles with a valid ADDIU presented
        drive(I_ADDIU, 1, 0, 0);
        chk_eq("rst_ready", id_ready, 0);
        tick();
        chk_eq("rst_ex_valid", ex_valid, 0);
        chk_eq("rst_ex_ctrl", ex_ctrl, 0);
        chk_eq("rst_mem_valid", mem_valid, 0);
        chk_eq("rst_wb_valid", wb_valid, 0);
        chk_eq("rst_md_busy", md_busy, 0);
        drive(I_ADDIU, 1, 0, 0);
        chk_eq("rst_ready2", id_ready, 0);
        tick();
        chk_eq("rst_ex_valid2", ex_valid, 0);
        chk_eq("rst_ctrl_all", {mem_ctrl, wb_ctrl}, 0);
        rst_n = 1'b1;
        drive(I_ADDIU, 1, 0, 0);
        chk_eq("addiu_ready", id_ready, 1);
        chk_eq("addiu_wdest", id_wdest, 2'b01);
        tick();
        chk_eq("addiu_ex_valid", ex_valid, 1);
        chk_eq("addiu_ex_ctrl", ex_ctrl, 5'b001_01);

        // LBU through EX, MEM, WB
        drive(I_LBU, 1, 0, 0);
        chk_eq("lbu_if_ctrl", id_if_ctrl, 0);
        tick();
        chk_eq("lbu_ex_ctrl", ex_ctrl, 5'b001_01);
        drive(I_LBU, 0, 0, 0);
        tick();
        chk_eq("idle_ex_bubble", {ex_valid, ex_ctrl}, 0);
        chk_eq("lbu_mem_valid", mem_valid, 1);
        chk_eq("lbu_mem_ctrl", mem_ctrl, 6'b0_1_01_0_1);
        drive(I_LBU, 0, 0, 0);
        tick();
        chk_eq("lbu_wb_valid", wb_valid, 1);
        chk_eq("lbu_wb_ctrl", wb_ctrl, 5'b11010);

        // load-use: LW issues, SUBU stalled one cycle then issues
        drive(I_LW, 1, 0, 0);
        tick();
        chk_eq("lw_ex_ctrl", ex_ctrl, 5'b001_01);
        drive(I_SUBU, 1, 1, 0);
        chk_eq("stall_ready", id_ready, 0);
        tick();
        chk_eq("stall_bubble", {ex_valid, ex_ctrl}, 0);
        chk_eq("lw_mem_ctrl", mem_ctrl, 6'b0_1_11_0_1);
        drive(I_SUBU, 1, 0, 0);
        chk_eq("subu_ready", id_ready, 1);
        chk_eq("subu_wdest", id_wdest, 2'b11);
        tick();
        chk_eq("subu_ex", {ex_valid, ex_ctrl}, {1'b1, 5'b010_00});

        // flush beats stall; flushed ADDIU never reaches WB
        drive(I_ADDIU, 1, 1, 1);
        chk_eq("flush_ready", id_ready, 1);
        tick();
        chk_eq("flush_ex_valid", ex_valid, 0);
        drive(I_ADDIU, 0, 0, 0);
        tick();
        chk_eq("flush_mem_valid", mem_valid, 0);
        chk_eq("subu_wb", {wb_valid, wb_ctrl}, {1'b1, 5'b00010});
        drive(I_ADDIU, 0, 0, 0);
        tick();
        chk_eq("flush_wb_valid", wb_valid, 0);

        // DIV occupancy, ADDU flows, MFLO waits for md_busy to fall
        drive(I_DIV, 1, 0, 0);
        chk_eq("div_ready", id_ready, 1);
        tick();
        chk_eq("div_ex_valid", ex_valid, 1);
        busy_cnt = md_busy ? 1 : 0;
        drive(I_ADDU, 1, 0, 0);
        chk_eq("addu_ready_busy", id_ready, 1);
        tick();
        chk_eq("addu_ex", {ex_valid, ex_ctrl}, {1'b1, 5'b001_00});
        if (md_busy) busy_cnt++;
        early_ready = 0;
        for (int i = 0; i < 40; i++) begin
            drive(I_MFLO, 1, 0, 0);
            if (!md_busy) break;
            if (id_ready) early_ready++;
            tick();
            if (md_busy) busy_cnt++;
        end
        chk_eq("md_busy_fell", md_busy, 0);
        chk_eq("md_busy_cycles", busy_cnt, 31);
        chk_eq("mflo_blocked", early_ready, 0);
        chk_eq("mflo_ready", id_ready, 1);
        tick();
        chk_eq("mflo_ex", {ex_valid, ex_ctrl}, {1'b1, 5'b111_00});

        // reset cancels an in-flight DIV
        drive(I_DIV, 1, 0, 0);
        tick();
        chk_eq("div2_busy", md_busy, 1);
        rst_n = 1'b0;
        drive(I_DIV, 0, 0, 0);
        tick();
        chk_eq("rst_cancels_md", md_busy, 0);
        rst_n = 1'b1;

        // link forms and branch/jump IF controls
        drive(I_JAL, 0, 0, 0);
        chk_eq("jal_gated", {id_if_ctrl, id_wdest}, 0);
        drive(I_JAL, 1, 0, 0);
        chk_eq("jal_if", id_if_ctrl, 2'b01);
        chk_eq("jal_wdest", id_wdest, 2'b10);
        tick();
        chk_eq("jal_ex", ex_ctrl, 5'b111_11);
        drive(I_BGEZAL, 1, 0, 0);
        chk_eq("bgezal_if", id_if_ctrl, 2'b10);
        chk_eq("bgezal_wdest", id_wdest, 2'b10);
        tick();
        chk_eq("bgezal_ex", ex_ctrl, 5'b111_11);
        drive(I_BEQ, 1, 0, 0);
        chk_eq("beq_if", id_if_ctrl, 2'b10);
        tick();
        chk_eq("bgezal_mem_wb", r_mem_wb_probe(), 0);
        drive(I_BEQ, 0, 0, 0);
        tick();
        chk_eq("bgezal_wb", {wb_valid, wb_ctrl}, {1'b1, 5'b00010});

        // unknown opcode
        drive(I_BAD, 1, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk_eq("bad_trap", illegal_instr, 1);
        chk_eq("bad_ready", id_ready, 1);
        tick();
        chk_eq("bad_ex_bubble", {ex_valid, ex_ctrl}, 0);
        drive(I_BAD, 0, 0, 0);
        chk_eq("bad_trap_pulse", illegal_instr, 0);
`else
        chk_eq("bad_no_trap", illegal_instr, 0);
        chk_eq("bad_ready", id_ready, 1);
        tick();
        chk_eq("bad_ex_nop", {ex_valid, ex_ctrl}, {1'b1, 5'b0});
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // MEM slice of the BGEZAL (a link op carries no memory access) plus its valid
    function automatic logic [31:0] r_mem_wb_probe();
        return {25'd0, ~mem_valid, mem_ctrl};
    endfunction

endmodule
